// File: rtl/dm_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl_if
// One requester's load/store channel into dm_access_ctrl.
//   req    requester -> ctrl  request valid, held until ack
//   we     requester -> ctrl  1 = store, 0 = load
//   width  requester -> ctrl  access width / extension code
//   addr   requester -> ctrl  byte address
//   wdata  requester -> ctrl  store data (sub-word in low bits)
//   pc     requester -> ctrl  instruction PC for the store trace
//   ack    ctrl -> requester  one-cycle completion pulse
//   rdata  ctrl -> requester  load result, valid with ack
//   err    ctrl -> requester  access rejected, valid with ack
// ---------------------------------------------------------------------------
interface dm_access_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, width, addr, wdata, pc,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, width, addr, wdata, pc,
        output ack, rdata, err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl
// Round-robin arbiter and sequencer in front of the word-organised data
// memory. Two requesters share the single memory word port; sub-word stores
// are done as read-modify-write, sub-word loads are extracted and extended,
// and illegal / misaligned / out-of-range accesses are answered with err.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   m0, m1       requester channels (slave side); m0 = MEM stage, m1 = loader
//   o_dm_adr     word-aligned byte address to memory
//   o_dm_wdata   word written to memory
//   o_dm_we      memory write enable
//   o_dm_pc      PC of the access in progress
//   i_dm_rdata   memory read word, combinational on o_dm_adr
// ---------------------------------------------------------------------------
module dm_access_ctrl #(
    parameter int DM_WORDS = 4096
) (
    input  logic               clk,
    input  logic               reset,
    dm_access_ctrl_if.slave    m0,
    dm_access_ctrl_if.slave    m1,
    output logic [31:0]        o_dm_adr,
    output logic [31:0]        o_dm_wdata,
    output logic               o_dm_we,
    output logic [31:0]        o_dm_pc,
    input  logic [31:0]        i_dm_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] W_WORD   = 3'b000;
    localparam logic [2:0] W_HALF_Z = 3'b001;
    localparam logic [2:0] W_HALF_S = 3'b010;
    localparam logic [2:0] W_BYTE_Z = 3'b011;
    localparam logic [2:0] W_BYTE_S = 3'b100;

    // First illegal byte address, one bit wider so the compare cannot wrap.
    localparam logic [32:0] ADDR_LIM = 33'(DM_WORDS) << 2;

    // Control state
    logic [1:0]  r_state;
    logic        r_last_m1;   // 1 = m1 was granted last, so m0 wins a tie
    logic        r_gnt_m1;    // port owning the access in flight

    // Latched request and results
    logic        r_we;
    logic [2:0]  r_width;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [31:0] r_old;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any_req;
    logic        w_gnt_m1;
    logic        w_is_half;
    logic        w_err;
    logic        w_resp;

    // Select byte/half out of a memory word and extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  a,
                                              input logic [2:0]  width);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  bs;
        logic signed [15:0] hs;
        b  = word[{a, 3'b000} +: 8];
        h  = word[{a[1], 4'b0000} +: 16];
        bs = b;
        hs = h;
        case (width)
            W_WORD:   f_extract = word;
            W_HALF_Z: f_extract = {16'd0, h};
            W_HALF_S: f_extract = 32'(hs);
            W_BYTE_Z: f_extract = {24'd0, b};
            W_BYTE_S: f_extract = 32'(bs);
            default:  f_extract = '0;
        endcase
    endfunction

    // Overlay the store's byte/half onto the old memory word.
    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [1:0]  a,
                                            input logic [2:0]  width);
        logic [31:0] m;
        m = old;
        case (width)
            W_BYTE_Z, W_BYTE_S: m[{a, 3'b000} +: 8]     = wd[7:0];
            W_HALF_Z, W_HALF_S: m[{a[1], 4'b0000} +: 16] = wd[15:0];
            default:            m = old;
        endcase
        f_merge = m;
    endfunction

    assign w_any_req = m0.req | m1.req;
    // m1 wins when it is alone, or on a tie when m0 had the last grant.
    assign w_gnt_m1  = m1.req & (~m0.req | ~r_last_m1);

    assign w_is_half = (r_width == W_HALF_Z) | (r_width == W_HALF_S);
    assign w_err     = (r_width > W_BYTE_S)
                     | (w_is_half & r_addr[0])
                     | ((r_width == W_WORD) & (|r_addr[1:0]))
                     | ({1'b0, r_addr} >= ADDR_LIM);

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last_m1 <= 1'b1;
            r_gnt_m1  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_m1  <= w_gnt_m1;
                        r_last_m1 <= w_gnt_m1;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_err || !r_we || (r_width == W_WORD))
                        r_state <= S_RESP;
                    else
                        r_state <= S_MERGE;
                end
                S_MERGE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---- request latch (IDLE) / memory capture (ACCESS) ----
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    r_we    <= w_gnt_m1 ? m1.we    : m0.we;
                    r_width <= w_gnt_m1 ? m1.width : m0.width;
                    r_addr  <= w_gnt_m1 ? m1.addr  : m0.addr;
                    r_wdata <= w_gnt_m1 ? m1.wdata : m0.wdata;
                    r_pc    <= w_gnt_m1 ? m1.pc    : m0.pc;
                end
            end
            S_ACCESS: begin
                r_old   <= i_dm_rdata;
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? '0 : f_extract(i_dm_rdata, r_addr[1:0], r_width);
            end
            default: ;
        endcase
    end

    // ---- memory port drive ----
    // The write enable is gated by reset directly so that a reset landing in
    // ACCESS or MERGE aborts the write in that same cycle.
    always_comb begin
        o_dm_adr   = '0;
        o_dm_pc    = '0;
        o_dm_wdata = '0;
        o_dm_we    = 1'b0;
        if (r_state == S_ACCESS || r_state == S_MERGE) begin
            o_dm_adr = {r_addr[31:2], 2'b00};
            o_dm_pc  = r_pc;
        end
        if (r_state == S_ACCESS && r_we && (r_width == W_WORD) && !w_err) begin
            o_dm_wdata = r_wdata;
            o_dm_we    = ~reset;
        end else if (r_state == S_MERGE) begin
            o_dm_wdata = f_merge(r_old, r_wdata, r_addr[1:0], r_width);
            o_dm_we    = ~reset;
        end
    end

    // ---- response to the granted port only ----
    assign w_resp   = (r_state == S_RESP) & ~reset;
    assign m0.ack   = w_resp & ~r_gnt_m1;
    assign m1.ack   = w_resp &  r_gnt_m1;
    assign m0.rdata = m0.ack ? r_rdata : '0;
    assign m1.rdata = m1.ack ? r_rdata : '0;
    assign m0.err   = m0.ack & r_err;
    assign m1.err   = m1.ack & r_err;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_access_ctrl
// Bench for dm_access_ctrl with a behavioural word memory. A vector table
// covers single accesses from either port; hand sequences cover contention,
// reset, and reset in the middle of a read-modify-write.
// ---------------------------------------------------------------------------
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dm_adr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;

    dm_access_ctrl_if m0_if ();
    dm_access_ctrl_if m1_if ();

    dm_access_ctrl #(.DM_WORDS(4096)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0         (m0_if),
        .m1         (m1_if),
        .o_dm_adr   (dm_adr),
        .o_dm_wdata (dm_wdata),
        .o_dm_we    (dm_we),
        .o_dm_pc    (dm_pc),
        .i_dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    // ---- behavioural memory with write recorder ----
    logic [31:0] mem [0:4095];
    logic        mem_clr = 1'b1;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    logic [31:0] wr_adr = '0;
    logic [31:0] wr_pc = '0;

    assign dm_rdata = mem[dm_adr[13:2]];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (dm_we) begin
            mem[dm_adr[13:2]] <= dm_wdata;
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
            wr_adr <= dm_adr;
            wr_pc  <= dm_pc;
        end
    end

    // ---- bookkeeping ----
    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          port;
        bit          we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;
    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit port, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Advance one clock, sample #1 later, and score any ack against the queue.
    task automatic step(output bit a0, output bit a1);
        exp_t e;
        @(posedge clk);
        #1;
        a0 = m0_if.ack;
        a1 = m1_if.ack;
        if (a0 || a1) begin
            chk("single_ack", 32'(a0 && a1), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(a1), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(a1), 32'(e.port));
                chk("rdata", a1 ? m1_if.rdata : m0_if.rdata, e.rdata);
                chk("err", 32'(a1 ? m1_if.err : m0_if.err), 32'(e.err));
            end
        end
    endtask

    task automatic drive(input bit port, input bit we, input logic [2:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc);
        if (port) begin
            m1_if.we = we; m1_if.width = width; m1_if.addr = addr;
            m1_if.wdata = wdata; m1_if.pc = pc; m1_if.req = 1'b1;
        end else begin
            m0_if.we = we; m0_if.width = width; m0_if.addr = addr;
            m0_if.wdata = wdata; m0_if.pc = pc; m0_if.req = 1'b1;
        end
    endtask

    task automatic do_reset();
        bit a0, a1;
        reset = 1'b1;
        step(a0, a1);
        step(a0, a1);
        reset = 1'b0;
    endtask

    // One access, then one idle cycle so the next starts from IDLE.
    task automatic do_vec(input vec_t v);
        bit a0, a1, got;
        int lat, c0, wc0;
        push_exp(v.port, v.exp_rdata, v.exp_err);
        drive(v.port, v.we, v.width, v.addr, v.wdata, v.pc);
        c0  = cyc;
        wc0 = wr_cnt;
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            step(a0, a1);
            lat++;
            got = v.port ? a1 : a0;
        end
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        if (v.we && !v.exp_err) begin
            chk("wr_count", 32'(wr_cnt - wc0), 32'd1);
            chk("wr_cycle", 32'(wr_cyc - c0), 32'(v.exp_lat - 1));
            chk("wr_adr", wr_adr, {v.addr[31:2], 2'b00});
            chk("wr_pc", wr_pc, v.pc);
            chk("mem_word", mem[v.addr[13:2]], v.exp_mem);
        end else begin
            chk("no_write", 32'(wr_cnt - wc0), 32'd0);
        end
        step(a0, a1);
    endtask

    // Both ports request together; each keeps req high until it has n acks.
    task automatic run_both(input int n0, input int n1);
        bit a0, a1;
        int left0, left1, guard;
        left0 = n0;
        left1 = n1;
        m0_if.req = (left0 > 0);
        m1_if.req = (left1 > 0);
        guard = 0;
        while ((left0 > 0 || left1 > 0) && guard < 40) begin
            step(a0, a1);
            guard++;
            if (a0) begin
                left0--;
                if (left0 <= 0) m0_if.req = 1'b0;
            end
            if (a1) begin
                left1--;
                if (left1 <= 0) m1_if.req = 1'b0;
            end
        end
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
        chk("contention_done", 32'(left0 + left1), 32'd0);
        if (sb.size() != 0) sb.delete();
        step(a0, a1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m0_ack"},   32'(m0_if.ack), 32'd0);
        chk({tag, "_m0_rdata"}, m0_if.rdata,    32'd0);
        chk({tag, "_m0_err"},   32'(m0_if.err), 32'd0);
        chk({tag, "_m1_ack"},   32'(m1_if.ack), 32'd0);
        chk({tag, "_m1_rdata"}, m1_if.rdata,    32'd0);
        chk({tag, "_m1_err"},   32'(m1_if.err), 32'd0);
        chk({tag, "_dm_we"},    32'(dm_we),     32'd0);
        chk({tag, "_dm_adr"},   dm_adr,         32'd0);
        chk({tag, "_dm_wdata"}, dm_wdata,       32'd0);
        chk({tag, "_dm_pc"},    dm_pc,          32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a0, a1;
        vec_t v;
        int   wc0;

        //          port we  width   addr          wdata         pc            rdata         err lat mem
        vecs[0]  = '{0, 1, 3'b000, 32'h0000_0010, 32'h1234_5678, 32'h0000_3000, 32'h0,        0, 2, 32'h1234_5678};
        vecs[1]  = '{0, 1, 3'b011, 32'h0000_0011, 32'h0000_00AB, 32'h0000_3004, 32'h0,        0, 3, 32'h1234_AB78};
        vecs[2]  = '{1, 1, 3'b000, 32'h0000_0010, 32'h80FF_7F01, 32'h0000_3008, 32'h0,        0, 2, 32'h80FF_7F01};
        vecs[3]  = '{0, 0, 3'b100, 32'h0000_0012, 32'h0,         32'h0000_300C, 32'hFFFF_FFFF, 0, 2, 32'h0};
        vecs[4]  = '{1, 0, 3'b011, 32'h0000_0011, 32'h0,         32'h0000_3010, 32'h0000_007F, 0, 2, 32'h0};
        vecs[5]  = '{0, 0, 3'b010, 32'h0000_0012, 32'h0,         32'h0000_3014, 32'hFFFF_80FF, 0, 2, 32'h0};
        vecs[6]  = '{1, 0, 3'b001, 32'h0000_0010, 32'h0,         32'h0000_3018, 32'h0000_7F01, 0, 2, 32'h0};
        vecs[7]  = '{0, 0, 3'b000, 32'h0000_0010, 32'h0,         32'h0000_301C, 32'h80FF_7F01, 0, 2, 32'h0};
        vecs[8]  = '{1, 1, 3'b001, 32'h0000_0012, 32'hFFFF_BEEF, 32'h0000_3020, 32'h0,        0, 3, 32'hBEEF_7F01};
        vecs[9]  = '{0, 1, 3'b100, 32'h0000_0013, 32'hFFFF_FF5A, 32'h0000_3024, 32'h0,        0, 3, 32'h5AEF_7F01};
        vecs[10] = '{0, 0, 3'b000, 32'h0000_0006, 32'h0,         32'h0000_3028, 32'h0,        1, 2, 32'h0};
        vecs[11] = '{1, 0, 3'b001, 32'h0000_0003, 32'h0,         32'h0000_302C, 32'h0,        1, 2, 32'h0};
        vecs[12] = '{0, 0, 3'b000, 32'h0000_4000, 32'h0,         32'h0000_3030, 32'h0,        1, 2, 32'h0};
        vecs[13] = '{1, 0, 3'b111, 32'h0000_0010, 32'h0,         32'h0000_3034, 32'h0,        1, 2, 32'h0};
        vecs[14] = '{0, 1, 3'b000, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0000_3038, 32'h0,        1, 2, 32'h0};
        vecs[15] = '{0, 1, 3'b101, 32'h0000_0010, 32'h0000_0055, 32'h0000_303C, 32'h0,        1, 2, 32'h0};
        vecs[16] = '{1, 1, 3'b000, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0000_3040, 32'h0,        0, 2, 32'hCAFE_F00D};
        vecs[17] = '{0, 0, 3'b000, 32'h0000_3FFC, 32'h0,         32'h0000_3044, 32'hCAFE_F00D, 0, 2, 32'h0};
        vecs[18] = '{1, 0, 3'b010, 32'h0000_3FFE, 32'h0,         32'h0000_3048, 32'hFFFF_CAFE, 0, 2, 32'h0};

        m0_if.req = 0; m0_if.we = 0; m0_if.width = '0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.pc = '0;
        m1_if.req = 0; m1_if.we = 0; m1_if.width = '0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.pc = '0;

        // Reset state
        do_reset();
        mem_clr = 1'b0;
        chk_outputs_zero("reset");
        step(a0, a1);
        chk_outputs_zero("idle");

        // Single accesses from the table
        for (int i = 0; i < 19; i++) do_vec(vecs[i]);

        // Continuous contention from reset: m0, m1, m0, m1
        do_reset();
        drive(0, 0, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_4000);
        drive(1, 0, 3'b000, 32'h0000_3FFC, 32'h0, 32'h0000_5000);
        push_exp(0, 32'h5AEF_7F01, 0);
        push_exp(1, 32'hCAFE_F00D, 0);
        push_exp(0, 32'h5AEF_7F01, 0);
        push_exp(1, 32'hCAFE_F00D, 0);
        run_both(2, 2);

        // Reset in the MERGE of a byte store aborts it
        v = '{0, 1, 3'b000, 32'h0000_0010, 32'h1234_5678, 32'h0000_3000, 32'h0, 0, 2, 32'h1234_5678};
        do_vec(v);
        wc0 = wr_cnt;
        drive(0, 1, 3'b011, 32'h0000_0011, 32'h0000_00AB, 32'h0000_3100);
        step(a0, a1);
        chk("access_no_we", 32'(dm_we), 32'd0);
        step(a0, a1);
        chk("merge_we", 32'(dm_we), 32'd1);
        chk("merge_wdata", dm_wdata, 32'h1234_AB78);
        reset = 1'b1;
        m0_if.req = 1'b0;
        #1;
        chk("reset_gates_we", 32'(dm_we), 32'd0);
        step(a0, a1);
        reset = 1'b0;
        #1;
        chk_outputs_zero("post_abort");
        chk("abort_no_write", 32'(wr_cnt - wc0), 32'd0);
        chk("abort_mem", mem[4], 32'h1234_5678);

        // First tie after reset goes to m0
        drive(0, 0, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_6000);
        drive(1, 0, 3'b000, 32'h0000_3FFC, 32'h0, 32'h0000_7000);
        push_exp(0, 32'h1234_5678, 0);
        push_exp(1, 32'hCAFE_F00D, 0);
        run_both(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
